// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, MEM-stage FSM encoding and address helper.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mem_state_e;

    // Data memory is word-addressed; byte offset bits are dropped.
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_mem_wb_reg.sv
// MEM/WB pipeline register. Loads a new write-back when load_i is set, otherwise inserts a bubble.
module pipe_mem_wb_reg
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              reg_write_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              reg_write_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   wb_data_o
);

    logic              reg_write_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   wb_data_q;

    // A bubble only needs to kill the write enable; rd/data are don't-care then.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_data_q   <= '0;
        end else if (load_i) begin
            reg_write_q <= reg_write_i;
            rd_q        <= rd_i;
            wb_data_q   <= wb_data_i;
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    assign reg_write_o = reg_write_q;
    assign rd_o        = rd_q;
    assign wb_data_o   = wb_data_q;

endmodule

// File: rtl/pipe_mem_wb_stage.sv
// MEM stage plus MEM/WB register: issues loads/stores on a req/ack port, stalls upstream
// until the access completes or times out, and registers the write-back result.
module pipe_mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   ALUout_i,
    input  logic [XLEN-1:0]   WD_i,
    input  logic [REG_AW-1:0] RD_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              dmem_err_o,
    output logic              RegWrite_o,
    output logic [REG_AW-1:0] RD_o,
    output logic [XLEN-1:0]   WBdata_o
);

    mem_state_e      state_q, state_d;
    logic [TO_W-1:0] cnt_q;
    logic            req_q, we_q, err_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic            mem_op, timeout;
    logic            wb_load;
    logic [XLEN-1:0] wb_data;

    assign mem_op  = MemRead_i | MemWrite_i;
    assign timeout = (cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mem_op) state_d = StBusy;
            StBusy: if (dmem_ack_i || timeout) state_d = StIdle;
        endcase
    end

    // An aborted load writes back zero so the destination register is still defined.
    always_comb begin
        stall_o = 1'b0;
        wb_load = 1'b0;
        wb_data = ALUout_i;
        unique case (state_q)
            StIdle: begin
                if (mem_op) stall_o = 1'b1;
                else        wb_load = 1'b1;
            end
            StBusy: begin
                if (dmem_ack_i) begin
                    wb_load = 1'b1;
                    if (MemtoReg_i) wb_data = dmem_rdata_i;
                end else if (timeout) begin
                    wb_load = 1'b1;
                    if (MemtoReg_i) wb_data = '0;
                end else begin
                    stall_o = 1'b1;
                end
            end
        endcase
    end

    // Request side; a store wins when both MemRead and MemWrite are set.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (state_q == StIdle) begin
            if (mem_op) begin
                req_q   <= 1'b1;
                we_q    <= MemWrite_i;
                addr_q  <= word_addr(ALUout_i);
                wdata_q <= WD_i;
                cnt_q   <= '0;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (dmem_ack_i || timeout) req_q <= 1'b0;
            if (!dmem_ack_i && timeout) err_q <= 1'b1;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_err_o   = err_q;

    pipe_mem_wb_reg u_mem_wb_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (wb_load),
        .reg_write_i (RegWrite_i),
        .rd_i        (RD_i),
        .wb_data_i   (wb_data),
        .reg_write_o (RegWrite_o),
        .rd_o        (RD_o),
        .wb_data_o   (WBdata_o)
    );

endmodule

// File: tb/tb_pipe_mem_wb_stage.sv
// Directed self-checking bench for pipe_mem_wb_stage.
module tb_pipe_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out, wd, rdata;
    logic [4:0]  rd;
    logic        reg_write, mem_to_reg, mem_read, mem_write, ack;
    logic        stall, req, we, err, reg_write_o;
    logic [31:0] addr, wdata, wb_data;
    logic [4:0]  rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_mem_wb_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ALUout_i     (alu_out),
        .WD_i         (wd),
        .RD_i         (rd),
        .RegWrite_i   (reg_write),
        .MemtoReg_i   (mem_to_reg),
        .MemRead_i    (mem_read),
        .MemWrite_i   (mem_write),
        .stall_o      (stall),
        .dmem_req_o   (req),
        .dmem_we_o    (we),
        .dmem_addr_o  (addr),
        .dmem_wdata_o (wdata),
        .dmem_ack_i   (ack),
        .dmem_rdata_i (rdata),
        .dmem_err_o   (err),
        .RegWrite_o   (reg_write_o),
        .RD_o         (rd_o),
        .WBdata_o     (wb_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        alu_out = 32'h0; wd = 32'h0; rd = 5'd0; reg_write = 1'b0;
        mem_to_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        ack = 1'b0; rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_nop();
        alu_out = 32'hFFFF_FFFF; reg_write = 1'b1; rd = 5'd31;
        tick(); tick();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", req); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", we); end
        n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr); end
        n_checks++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_checks++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got=%b exp=0", reg_write_o); end
        n_checks++; if (rd_o !== 5'd0) begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", rd_o); end
        n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wbdata got=%h exp=0", wb_data); end
        set_nop();
        rst = 1'b1;
    endtask

    task automatic test_alu_op();
        alu_out = 32'h1234; reg_write = 1'b1; rd = 5'd5;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got=%b exp=0", stall); end
        tick();
        n_checks++; if (reg_write_o !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite got=%b exp=1", reg_write_o); end
        n_checks++; if (rd_o !== 5'd5) begin n_fail++; $display("FAIL alu_rd got=%0d exp=5", rd_o); end
        n_checks++; if (wb_data !== 32'h1234) begin n_fail++; $display("FAIL alu_wbdata got=%h exp=00001234", wb_data); end
        n_checks++; if (stall !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL alu_nostall stall=%b req=%b exp=0/0", stall, req); end
        set_nop();
    endtask

    task automatic test_load();
        alu_out = 32'h103; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; rd = 5'd7;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_idle got=%b exp=1", stall); end
        tick();
        n_checks++; if (req !== 1'b1 || we !== 1'b0) begin n_fail++; $display("FAIL load_req req=%b we=%b exp=1/0", req, we); end
        n_checks++; if (addr !== 32'h100) begin n_fail++; $display("FAIL load_addr got=%h exp=00000100", addr); end
        n_checks++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL load_bubble got=%b exp=0", reg_write_o); end
        ack = 1'b1; rdata = 32'hCAFE_0001;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_stall_ack got=%b exp=0", stall); end
        tick();
        set_nop();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL load_req_drop got=%b exp=0", req); end
        n_checks++; if (reg_write_o !== 1'b1 || rd_o !== 5'd7) begin n_fail++; $display("FAIL load_wb regwrite=%b rd=%0d exp=1/7", reg_write_o, rd_o); end
        n_checks++; if (wb_data !== 32'hCAFE_0001) begin n_fail++; $display("FAIL load_wbdata got=%h exp=cafe0001", wb_data); end
    endtask

    task automatic test_store();
        alu_out = 32'h40; wd = 32'hA5A5_A5A5; mem_write = 1'b1; rd = 5'd2;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL store_stall_idle got=%b exp=1", stall); end
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) ack = 1'b1;
            #1;
            n_checks++; if (req !== 1'b1 || we !== 1'b1) begin n_fail++; $display("FAIL store_req[%0d] req=%b we=%b exp=1/1", k, req, we); end
            n_checks++; if (addr !== 32'h40 || wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL store_bus[%0d] addr=%h wdata=%h exp=00000040/a5a5a5a5", k, addr, wdata); end
            n_checks++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL store_bubble[%0d] got=%b exp=0", k, reg_write_o); end
            n_checks++; if (stall !== (k != 2)) begin n_fail++; $display("FAIL store_stall[%0d] got=%b exp=%b", k, stall, (k != 2)); end
            tick();
        end
        set_nop();
        n_checks++; if (req !== 1'b0 || reg_write_o !== 1'b0) begin n_fail++; $display("FAIL store_done req=%b regwrite=%b exp=0/0", req, reg_write_o); end
    endtask

    task automatic test_timeout();
        alu_out = 32'h80; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; rd = 5'd9;
        tick();
        for (int i = 0; i < 15; i++) begin
            n_checks++; if (stall !== 1'b1 || req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d] stall=%b req=%b err=%b exp=1/1/0", i, stall, req, err); end
            tick();
        end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_release got=%b exp=0", stall); end
        tick();
        set_nop();
        n_checks++; if (err !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL to_err err=%b req=%b exp=1/0", err, req); end
        n_checks++; if (reg_write_o !== 1'b1 || rd_o !== 5'd9 || wb_data !== 32'h0) begin n_fail++; $display("FAIL to_wb regwrite=%b rd=%0d data=%h exp=1/9/0", reg_write_o, rd_o, wb_data); end
        ack = 1'b1;
        tick(); tick(); tick();
        ack = 1'b0;
        n_checks++; if (err !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL to_sticky err=%b req=%b exp=1/0", err, req); end
    endtask

    task automatic test_reset_mid_access();
        alu_out = 32'h200; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; rd = 5'd12;
        tick(); tick();
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=1", req); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_nop();
        n_checks++; if (req !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clear req=%b err=%b exp=0/0", req, err); end
        n_checks++; if (reg_write_o !== 1'b0 || rd_o !== 5'd0 || wb_data !== 32'h0 || addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_outs regwrite=%b rd=%0d data=%h addr=%h exp=0", reg_write_o, rd_o, wb_data, addr); end
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_late_stall got=%b exp=0", stall); end
        tick();
        ack = 1'b0;
        n_checks++; if (reg_write_o !== 1'b0 || wb_data !== 32'h0 || req !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack regwrite=%b data=%h req=%b exp=0/0/0", reg_write_o, wb_data, req); end
    endtask

    task automatic test_back_to_back();
        alu_out = 32'h10; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; rd = 5'd3;
        tick();
        ack = 1'b1; rdata = 32'h1111_2222;
        tick();
        set_nop();
        alu_out = 32'h55; reg_write = 1'b1; rd = 5'd4;
        #1;
        n_checks++; if (reg_write_o !== 1'b1 || rd_o !== 5'd3 || wb_data !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_load regwrite=%b rd=%0d data=%h exp=1/3/11112222", reg_write_o, rd_o, wb_data); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%b exp=0", stall); end
        tick();
        set_nop();
        n_checks++; if (reg_write_o !== 1'b1 || rd_o !== 5'd4 || wb_data !== 32'h55) begin n_fail++; $display("FAIL b2b_alu regwrite=%b rd=%0d data=%h exp=1/4/00000055", reg_write_o, rd_o, wb_data); end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
